vm_result_decoder: RTL and testbench

- Consumer end of the vending machine's 6-beat result burst (valid / result / num serial stream).
- Deserialises one burst into parallel registers: purchased item, change coin counts and per-item sold counts.
- Computes the total change value and presents the record to downstream logic over a valid/ready handshake.
- Flags malformed bursts and records that could not be delivered.

---
 rtl/vm_result_decoder.sv | 179 +++++++++++++++++
 tb/tb_vm_result_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_result_decoder.sv
// Result-burst decoder for the vending machine.
// Collects one NUM_ITEMS-beat burst into staging registers, then loads a
// registered record (item, change coins, change total, sold counts) that is
// handed downstream over a valid/ready handshake. Malformed bursts and
// records that arrive while the output is still occupied are reported with
// one-cycle error pulses.
module vm_result_decoder #(
  parameter int NUM_ITEMS = 6,
  parameter int NUM_W     = 6,
  parameter int RES_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [RES_W-1:0]           in_result,
  input  logic [NUM_W-1:0]           in_num,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [2:0]                 out_item,
  output logic [RES_W-1:0]           out_c50,
  output logic [RES_W-1:0]           out_c20,
  output logic [RES_W-1:0]           out_c10,
  output logic [RES_W-1:0]           out_c5,
  output logic [RES_W-1:0]           out_c1,
  output logic [10:0]                out_change,
  output logic [NUM_ITEMS*NUM_W-1:0] out_sold,
  output logic                       err_frame,
  output logic                       err_overrun
);

  localparam int LAST = NUM_ITEMS - 1;
  localparam int CNT_W = $clog2(NUM_ITEMS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LAST);
  localparam logic [RES_W-1:0] MAX_ITEM  = RES_W'(NUM_ITEMS);

  typedef enum logic {S_IDLE, S_BEAT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture, complete, gap;

  // Staging for beats 0..LAST-1; the last beat is consumed straight from the inputs.
  logic [RES_W-1:0] res_p0 [LAST];
  logic [NUM_W-1:0] num_p0 [LAST];

  logic                       bad_item, load, overrun, frame;
  logic [NUM_ITEMS*NUM_W-1:0] sold_d;

  // Change total from coin counts using shift-add weights (50=32+16+2, 20=16+4, 10=8+2, 5=4+1).
  function automatic logic [10:0] change_sum(
    input logic [RES_W-1:0] c50,
    input logic [RES_W-1:0] c20,
    input logic [RES_W-1:0] c10,
    input logic [RES_W-1:0] c5,
    input logic [RES_W-1:0] c1
  );
    logic [10:0] a50, a20, a10, a5, a1;
    a50 = 11'(c50);
    a20 = 11'(c20);
    a10 = 11'(c10);
    a5  = 11'(c5);
    a1  = 11'(c1);
    return (a50 << 5) + (a50 << 4) + (a50 << 1)
         + (a20 << 4) + (a20 << 2)
         + (a10 << 3) + (a10 << 1)
         + (a5 << 2) + a5
         + a1;
  endfunction

  // Collector state and beat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Collector next state: capture beats, detect completion and mid-burst gaps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    complete = 1'b0;
    gap      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = S_BEAT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_BEAT: begin
        if (in_valid) begin
          capture = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            complete = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          gap     = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Staging capture; a gap throws away the partial burst.
  always_ff @(posedge clk) begin
    if (rst || gap) begin
      for (int i = 0; i < LAST; i++) begin
        res_p0[i] <= '0;
        num_p0[i] <= '0;
      end
    end else if (capture && cnt_q != LAST_BEAT) begin
      res_p0[cnt_q] <= in_result;
      num_p0[cnt_q] <= in_num;
    end
  end

  // Completion decisions and sold-count packing (last beat taken from inputs).
  always_comb begin
    bad_item = res_p0[0] > MAX_ITEM;
    load     = complete && !bad_item && (!out_valid || out_ready);
    overrun  = complete && !bad_item && out_valid && !out_ready;
    frame    = gap || (complete && bad_item);
    sold_d   = '0;
    for (int i = 0; i < LAST; i++) begin
      sold_d[i*NUM_W +: NUM_W] = num_p0[i];
    end
    sold_d[LAST*NUM_W +: NUM_W] = in_num;
  end

  // ---- output record stage ----
  // Record register, handshake and error pulses; a load wins over a consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_item    <= '0;
      out_c50     <= '0;
      out_c20     <= '0;
      out_c10     <= '0;
      out_c5      <= '0;
      out_c1      <= '0;
      out_change  <= '0;
      out_sold    <= '0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= frame;
      err_overrun <= overrun;
      if (load) begin
        out_valid  <= 1'b1;
        out_item   <= res_p0[0][2:0];
        out_c50    <= res_p0[1];
        out_c20    <= res_p0[2];
        out_c10    <= res_p0[3];
        out_c5     <= res_p0[4];
        out_c1     <= in_result;
        out_change <= change_sum(res_p0[1], res_p0[2], res_p0[3], res_p0[4], in_result);
        out_sold   <= sold_d;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vm_result_decoder.sv
// Bench for vm_result_decoder: drives directed and random result bursts,
// keeps a record-mailbox model of the decoder, and checks delivered records
// and error pulses against expectation queues from a separate monitor.
module tb_vm_result_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_result = '0;
  logic [5:0]  in_num = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [2:0]  out_item;
  logic [3:0]  out_c50, out_c20, out_c10, out_c5, out_c1;
  logic [10:0] out_change;
  logic [35:0] out_sold;
  logic        err_frame, err_overrun;

  vm_result_decoder #(.NUM_ITEMS(6), .NUM_W(6), .RES_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .in_num(in_num), .out_ready(out_ready), .out_valid(out_valid),
    .out_item(out_item), .out_c50(out_c50), .out_c20(out_c20),
    .out_c10(out_c10), .out_c5(out_c5), .out_c1(out_c1),
    .out_change(out_change), .out_sold(out_sold),
    .err_frame(err_frame), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  item;
    logic [3:0]  c50, c20, c10, c5, c1;
    logic [10:0] change;
    logic [35:0] sold;
  } rec_t;

  rec_t expq[$];     // records the model says will be delivered, in order
  bit   errq[$];     // expected error pulses: 0 = frame, 1 = overrun
  bit   mvalid = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   ready_mode = 1;  // 0 never, 1 always, 2 random, 3 only on final beat

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t make_rec(input logic [5:0][3:0] res, input logic [5:0][5:0] num);
    rec_t r;
    int   ch;
    r.item = res[0][2:0];
    r.c50  = res[1];
    r.c20  = res[2];
    r.c10  = res[3];
    r.c5   = res[4];
    r.c1   = res[5];
    ch = 50 * res[1] + 20 * res[2] + 10 * res[3] + 5 * res[4] + res[5];
    r.change = 11'(ch);
    for (int k = 0; k < 6; k++) r.sold[k*6 +: 6] = num[k];
    return r;
  endfunction

  function automatic bit pick_ready(input int k);
    case (ready_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom);
      default: return (k == 5);
    endcase
  endfunction

  // One clock edge of the reference model: a decoder holding at most one record.
  task automatic tick(input bit done, input bit gap, input rec_t r, input bit bad);
    bit load;
    @(posedge clk);
    load = 1'b0;
    if (rst) begin
      expq.delete();
      errq.delete();
      mvalid = 1'b0;
    end else begin
      if (gap) errq.push_back(1'b0);
      if (done) begin
        if (bad) errq.push_back(1'b0);
        else if (!mvalid || out_ready) load = 1'b1;
        else errq.push_back(1'b1);
      end
      if (load) begin
        mvalid = 1'b1;
        expq.push_back(r);
      end else if (mvalid && out_ready) begin
        mvalid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = (ready_mode == 3) ? 1'b0 : pick_ready(0);
      in_valid  = 1'b0;
      tick(1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic send_burst(input logic [5:0][3:0] res, input logic [5:0][5:0] num,
                            input int gap_at, input int rst_at);
    rec_t r;
    bit   bad;
    r   = make_rec(res, num);
    bad = (res[0] > 6);
    for (int k = 0; k < 6; k++) begin
      out_ready = pick_ready(k);
      if (k == rst_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        tick(1'b0, 1'b0, r, 1'b0);
        rst = 1'b0;
        return;
      end
      if (k == gap_at) begin
        in_valid = 1'b0;
        tick(1'b0, 1'b1, r, 1'b0);
        return;
      end
      in_valid  = 1'b1;
      in_result = res[k];
      in_num    = num[k];
      tick(k == 5, 1'b0, r, bad);
    end
    in_valid  = 1'b0;
    in_result = 4'($urandom);
    in_num    = 6'($urandom);
  endtask

  // Monitor: compares delivered records and error pulses against the queues.
  rec_t act_rec, exp_rec;
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 128'(out_valid), 128'(mvalid));
      if (out_valid && out_ready) begin
        act_rec = {out_item, out_c50, out_c20, out_c10, out_c5, out_c1, out_change, out_sold};
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL record_unexpected: got %0h expected none", act_rec);
        end else begin
          exp_rec = expq.pop_front();
          check("record", 128'(act_rec), 128'(exp_rec));
        end
      end
      if (err_frame) begin
        n_vec++;
        if (errq.size() == 0 || errq[0] != 1'b0) begin
          n_bad++;
          $display("FAIL err_frame: got pulse expected %0s", errq.size() == 0 ? "none" : "overrun");
        end
        if (errq.size() != 0) void'(errq.pop_front());
      end
      if (err_overrun) begin
        n_vec++;
        if (errq.size() == 0 || errq[0] != 1'b1) begin
          n_bad++;
          $display("FAIL err_overrun: got pulse expected %0s", errq.size() == 0 ? "none" : "frame");
        end
        if (errq.size() != 0) void'(errq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [5:0][3:0] res;
  logic [5:0][5:0] num;

  initial begin
    // reset for two cycles
    rst = 1'b1;
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    check("reset_outputs", 128'({out_valid, out_item, out_c50, out_c20, out_c10, out_c5,
                                 out_c1, out_change, out_sold, err_frame, err_overrun}), 128'(0));
    ready_mode = 1;
    idle(3);

    // basic decode, 62 cents change
    res = 24'h201013;
    num = {6'd0, 6'd0, 6'd0, 6'd4, 6'd0, 6'd1};
    send_burst(res, num, -1, -1);
    idle(3);

    // gap after beat 2, then a good burst
    res = 24'h123454;
    num = {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    send_burst(res, num, 3, -1);
    idle(1);
    res = 24'h321102;
    num = {6'd63, 6'd0, 6'd7, 6'd9, 6'd1, 6'd2};
    send_burst(res, num, -1, -1);
    idle(2);

    // stalled output: second back-to-back burst overruns
    ready_mode = 0;
    res = 24'h010001;
    num = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    send_burst(res, num, -1, -1);
    res = 24'h543212;
    send_burst(res, num, -1, -1);
    idle(2);
    ready_mode = 1;
    idle(3);

    // completion coincides with consume of the pending record
    ready_mode = 0;
    res = 24'h111115;
    send_burst(res, num, -1, -1);
    idle(1);
    ready_mode = 3;
    res = 24'h222226;
    send_burst(res, num, -1, -1);
    ready_mode = 1;
    idle(3);

    // max counts, bad item id
    res = 24'hFFFFF6;
    num = {6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63};
    send_burst(res, num, -1, -1);
    idle(2);
    res = 24'h000007;
    send_burst(res, num, -1, -1);
    idle(2);

    // reset mid-burst with a record pending
    ready_mode = 0;
    res = 24'h000103;
    send_burst(res, num, -1, -1);
    send_burst(res, num, -1, 3);
    check("reset_mid_outputs", 128'({out_valid, out_item, out_change, out_sold, err_frame, err_overrun}),
          128'(0));
    ready_mode = 1;
    idle(4);

    // randomized bursts
    ready_mode = 2;
    for (int b = 0; b < 80; b++) begin
      for (int k = 0; k < 6; k++) begin
        res[k] = 4'($urandom);
        num[k] = 6'($urandom);
      end
      res[0] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      send_burst(res, num, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : -1, -1);
      idle($urandom_range(0, 2));
    end

    ready_mode = 1;
    idle(5);
    check("drain_records", 128'(expq.size()), 128'(0));
    check("drain_errors", 128'(errq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
